mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_SIZE, default 32, sets the address width.
REQ-002 Parameter XLEN, default 32, sets the data width.
REQ-003 Parameter STARVE_MAX, default 3, is the number of consecutive fetch losses before fetch is forced to win (legal range 1..15).
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset: asserting it (low) immediately forces the reset state, and release is sampled on clk.
REQ-006 if_req  in  1  fetch request; held with if_addr stable until if_ready.
REQ-007 if_addr  in  ADDR_SIZE  fetch address.
REQ-008 if_flush  in  1  pipeline redirect; cancels any fetch accepted but not yet completed.
REQ-009 if_ready  out  1  one-cycle pulse that ends a fetch; if_rdata is valid in that cycle.
REQ-010 if_rdata  out  XLEN  fetched instruction.
REQ-011 d_req, d_we  in  1 each  data request and write enable; held stable until d_ready.
REQ-012 d_addr  in  ADDR_SIZE; d_wdata  in  XLEN; d_wmask  in  XLEN/8  data address, write data and byte enables.
REQ-013 d_ready  out  1; d_rdata  out  XLEN  one-cycle completion pulse; read data is valid with the pulse.
REQ-014 mem_req, mem_we  out  1 each; mem_addr  out  ADDR_SIZE; mem_wdata  out  XLEN; mem_wmask  out  XLEN/8  shared memory port request.
REQ-015 mem_gnt  in  1  memory accepts the request in any cycle where mem_req and mem_gnt are both 1.
REQ-016 mem_rvalid  in  1; mem_rdata  in  XLEN  single response per accepted request, for reads and writes alike.
REQ-017 stall_f, stall_m  out  1 each  fetch and data requester is pending and not completing this cycle.

Function
REQ-018 States: IDLE, ISSUE_F, ISSUE_D, WAIT_F, WAIT_D; one transaction outstanding at most.
REQ-019 IDLE: d_req=1 -> ISSUE_D; else if_req=1 -> ISSUE_F; if both are 1, data wins unless starve_cnt==STARVE_MAX, in which case fetch wins.
REQ-020 starve_cnt, 4 bits: +1 when both requests are present in IDLE and data wins; cleared when fetch wins; saturates at 15.
REQ-021 In ISSUE_x, mem_req=1 and the mem_* fields are driven from the latched requester's inputs; on mem_gnt=1 -> WAIT_x.
REQ-022 In WAIT_x with mem_rvalid=1, the matching x_ready is 1 that cycle, x_rdata=mem_rdata, and the state -> IDLE.
REQ-023 Minimum access is 3 cycles: request seen in cycle N, mem_req in N+1 (gnt in N+1), response at the earliest in N+2.
REQ-024 mem_req=0 outside ISSUE states; mem_we=0 for fetches; mem_wmask=0 for reads.
REQ-025 if_flush=1 in ISSUE_F or WAIT_F sets the drop flag. The transaction still completes on the memory side, but if_ready stays 0 at its end.
REQ-026 The drop flag clears on the return to IDLE. if_flush in IDLE has no effect.
REQ-027 mem_rvalid outside WAIT states is ignored; no output changes.
REQ-028 A requester dropping its req before ready is a protocol error. The transaction completes and its ready pulse is still generated.
REQ-029 stall_f = if_req & ~if_ready; stall_m = d_req & ~d_ready.
REQ-030 if_rdata and d_rdata hold their last completed value when not ready.

Reset
REQ-031 While reset=0: state=IDLE, starve_cnt=0, drop flag=0, and all outputs=0, including if_rdata, d_rdata and mem_*. The stall outputs are forced to 0 regardless of the request inputs.
REQ-032 Reset asserted mid-transaction abandons it. After release the arbiter issues no ready pulse for it, and a stale mem_rvalid is ignored under REQ-027.

Verification
REQ-033 Single fetch: if_req=1, if_addr=0x100, gnt immediate, rvalid 1 cycle later with 0x00000013 -> mem_req in cycle 1, if_ready and if_rdata=0x13 in cycle 2, stall_f=1 in cycles 0-1.
REQ-034 Simultaneous requests: if_req and d_req both at cycle 0 (d read at 0x2000) -> the data access is issued first and d_ready precedes if_ready; starve_cnt ends at 0 after the fetch wins.
REQ-035 Starvation: d_req held continuously with back-to-back new accesses, if_req held -> after 3 data wins, fetch wins the 4th arbitration.
REQ-036 Flush: if_flush pulsed in WAIT_F -> mem_rvalid is consumed, if_ready stays 0, and the next fetch at a new address completes normally.
REQ-037 Write plus reset: d_we=1, d_wmask=4'b0011, d_wdata=0xDEADBEEF -> mem_we=1 and mem_wmask=0011 in ISSUE_D. A reset pulse during WAIT_D returns the arbiter to IDLE, and a later mem_rvalid produces no d_ready.
REQ-038 Delayed grant: mem_gnt held 0 for 4 cycles -> mem_req and the mem_* fields stay stable, with no ready pulse until grant plus response.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter: shares one memory port between a fetch and a data requester
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_SIZE  = 32,
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [ADDR_SIZE-1:0] if_addr,
  input  logic                 if_flush,
  output logic                 if_ready,
  output logic [XLEN-1:0]      if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [ADDR_SIZE-1:0] d_addr,
  input  logic [XLEN-1:0]      d_wdata,
  input  logic [XLEN/8-1:0]    d_wmask,
  output logic                 d_ready,
  output logic [XLEN-1:0]      d_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [XLEN-1:0]      mem_wdata,
  output logic [XLEN/8-1:0]    mem_wmask,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [XLEN-1:0]      mem_rdata,
  output logic                 stall_f,
  output logic                 stall_m
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE_F = 3'd1,
    S_ISSUE_D = 3'd2,
    S_WAIT_F  = 3'd3,
    S_WAIT_D  = 3'd4
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              drop_q, drop_d;
  logic [XLEN-1:0]   if_rdata_q, d_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      starve_q   <= 4'd0;
      drop_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
      if (if_ready) if_rdata_q <= mem_rdata;
      if (d_ready)  d_rdata_q  <= mem_rdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    drop_d    = drop_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if_ready  = 1'b0;
    d_ready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (d_req && if_req) begin
          // Data normally wins a tie; fetch is forced through once it has lost enough times.
          if (starve_q == STARVE_LIM) begin
            state_d  = S_ISSUE_F;
            starve_d = 4'd0;
          end else begin
            state_d = S_ISSUE_D;
            if (starve_q != 4'hF) starve_d = starve_q + 4'd1;
          end
        end else if (d_req) begin
          state_d = S_ISSUE_D;
        end else if (if_req) begin
          state_d  = S_ISSUE_F;
          starve_d = 4'd0;
        end
      end

      S_ISSUE_F: begin
        mem_req  = 1'b1;
        mem_addr = if_addr;
        if (if_flush) drop_d = 1'b1;
        if (mem_gnt)  state_d = S_WAIT_F;
      end

      S_ISSUE_D: begin
        mem_req   = 1'b1;
        mem_addr  = d_addr;
        mem_we    = d_we;
        mem_wdata = d_wdata;
        mem_wmask = d_we ? d_wmask : '0;
        if (mem_gnt) state_d = S_WAIT_D;
      end

      S_WAIT_F: begin
        if (if_flush) drop_d = 1'b1;
        if (mem_rvalid) begin
          // A flush arriving with the response still cancels the delivery.
          if_ready = ~drop_q & ~if_flush;
          state_d  = S_IDLE;
          drop_d   = 1'b0;
        end
      end

      S_WAIT_D: begin
        if (mem_rvalid) begin
          d_ready = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign if_rdata = if_ready ? mem_rdata : if_rdata_q;
  assign d_rdata  = d_ready  ? mem_rdata : d_rdata_q;

  // Stalls are gated by reset directly so they read 0 while reset is held.
  assign stall_f = reset & if_req & ~if_ready;
  assign stall_m = reset & d_req  & ~d_ready;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, d_req, d_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wmask;
  logic        if_ready, d_ready, mem_req, mem_we, stall_f, stall_m;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_SIZE(32), .XLEN(32), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; if_req = 1'b1; d_req = 1'b1; if_flush = 1'b0; d_we = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; d_wmask = 4'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    next(); next(); mid();
    n_total++; if ({stall_f, stall_m} !== 2'b00) $display("FAIL rst_stall: got %b want 00", {stall_f, stall_m}); else n_pass++;
    n_total++; if ({mem_req, mem_we, mem_addr, mem_wmask} !== 38'h0) $display("FAIL rst_mem: got req=%b addr=%h want 0", mem_req, mem_addr); else n_pass++;
    n_total++; if ({if_ready, d_ready, if_rdata, d_rdata} !== 66'h0) $display("FAIL rst_resp: got if_rdata=%h d_rdata=%h want 0", if_rdata, d_rdata); else n_pass++;
    next(); if_req = 1'b0; d_req = 1'b0; reset = 1'b1;
    next();
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 32'h100;
    mid();
    n_total++; if ({mem_req, stall_f, if_ready} !== 3'b010) $display("FAIL sf_c0: got req/stall/rdy=%b want 010", {mem_req, stall_f, if_ready}); else n_pass++;
    next(); mem_gnt = 1'b1;
    mid();
    n_total++; if ({mem_req, mem_we, mem_wmask, stall_f} !== 7'b1_0_0000_1) $display("FAIL sf_c1: got req=%b we=%b mask=%b stall=%b want 1 0 0000 1", mem_req, mem_we, mem_wmask, stall_f); else n_pass++;
    n_total++; if (mem_addr !== 32'h100) $display("FAIL sf_addr: got %h want 00000100", mem_addr); else n_pass++;
    next(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    mid();
    n_total++; if ({if_ready, stall_f, mem_req} !== 3'b100) $display("FAIL sf_c2: got rdy/stall/req=%b want 100", {if_ready, stall_f, mem_req}); else n_pass++;
    n_total++; if (if_rdata !== 32'h13) $display("FAIL sf_rdata: got %h want 00000013", if_rdata); else n_pass++;
    next(); if_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    mid();
    n_total++; if ({if_ready, if_rdata} !== {1'b0, 32'h13}) $display("FAIL sf_hold: got rdy=%b rdata=%h want 0 00000013", if_ready, if_rdata); else n_pass++;
    next();
  endtask

  task automatic test_simultaneous();
    if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
    mid();
    n_total++; if ({mem_req, stall_f, stall_m} !== 3'b011) $display("FAIL sim_c0: got %b want 011", {mem_req, stall_f, stall_m}); else n_pass++;
    next(); mem_gnt = 1'b1;
    mid();
    n_total++; if ({mem_req, mem_we, mem_wmask, mem_addr} !== {1'b1, 1'b0, 4'h0, 32'h2000}) $display("FAIL sim_issue_d: got req=%b we=%b addr=%h want 1 0 00002000", mem_req, mem_we, mem_addr); else n_pass++;
    next(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
    mid();
    n_total++; if ({d_ready, if_ready, stall_f, stall_m} !== 4'b1010) $display("FAIL sim_dready: got %b want 1010", {d_ready, if_ready, stall_f, stall_m}); else n_pass++;
    n_total++; if (d_rdata !== 32'hAAAA_5555) $display("FAIL sim_drdata: got %h want aaaa5555", d_rdata); else n_pass++;
    next(); d_req = 1'b0; mem_rvalid = 1'b0;
    mid();
    n_total++; if (dut.starve_q !== 4'd1) $display("FAIL sim_starve1: got %0d want 1", dut.starve_q); else n_pass++;
    next(); mem_gnt = 1'b1;
    mid();
    n_total++; if ({mem_req, mem_addr} !== {1'b1, 32'h200}) $display("FAIL sim_issue_f: got req=%b addr=%h want 1 00000200", mem_req, mem_addr); else n_pass++;
    next(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
    mid();
    n_total++; if ({if_ready, if_rdata} !== {1'b1, 32'h0050_0093}) $display("FAIL sim_ifready: got rdy=%b rdata=%h want 1 00500093", if_ready, if_rdata); else n_pass++;
    next(); if_req = 1'b0; mem_rvalid = 1'b0;
    mid();
    n_total++; if (dut.starve_q !== 4'd0) $display("FAIL sim_starve0: got %0d want 0", dut.starve_q); else n_pass++;
    next();
  endtask

  task automatic test_starvation();
    logic        exp_fetch;
    logic [31:0] exp_addr;
    if_req = 1'b1; if_addr = 32'h400; d_req = 1'b1; d_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d_addr = 32'h3000 + 32'(4 * i);
      exp_fetch = (i == 3);
      exp_addr  = exp_fetch ? 32'h400 : 32'h3000 + 32'(4 * i);
      next(); mem_gnt = 1'b1;
      mid();
      n_total++; if (mem_addr !== exp_addr) $display("FAIL starve_addr%0d: got %h want %h", i, mem_addr, exp_addr); else n_pass++;
      next(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h100 + 32'(i);
      mid();
      n_total++; if ({if_ready, d_ready} !== (exp_fetch ? 2'b10 : 2'b01)) $display("FAIL starve_rdy%0d: got %b want %b", i, {if_ready, d_ready}, exp_fetch ? 2'b10 : 2'b01); else n_pass++;
      next(); mem_rvalid = 1'b0;
    end
    if_req = 1'b0; d_req = 1'b0;
    next();
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h500;
    next(); mem_gnt = 1'b1;
    next(); mem_gnt = 1'b0; if_flush = 1'b1;
    mid();
    n_total++; if (if_ready !== 1'b0) $display("FAIL fl_wait: got %b want 0", if_ready); else n_pass++;
    next(); if_flush = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0BAD;
    mid();
    n_total++; if ({if_ready, if_rdata} !== {1'b0, 32'h103}) $display("FAIL fl_drop: got rdy=%b rdata=%h want 0 00000103", if_ready, if_rdata); else n_pass++;
    next(); mem_rvalid = 1'b0; if_addr = 32'h600;
    mid();
    n_total++; if ({mem_req, stall_f} !== 2'b01) $display("FAIL fl_idle: got %b want 01", {mem_req, stall_f}); else n_pass++;
    next(); mem_gnt = 1'b1;
    mid();
    n_total++; if (mem_addr !== 32'h600) $display("FAIL fl_newaddr: got %h want 00000600", mem_addr); else n_pass++;
    next(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
    mid();
    n_total++; if ({if_ready, if_rdata} !== {1'b1, 32'h1234}) $display("FAIL fl_refetch: got rdy=%b rdata=%h want 1 00001234", if_ready, if_rdata); else n_pass++;
    next(); mem_rvalid = 1'b0; if_req = 1'b0;
    next();
  endtask

  task automatic test_dropped_req();
    if_req = 1'b1; if_addr = 32'h700;
    next(); if_req = 1'b0; mem_gnt = 1'b1;
    mid();
    n_total++; if ({mem_req, stall_f} !== 2'b10) $display("FAIL drq_issue: got %b want 10", {mem_req, stall_f}); else n_pass++;
    next(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h42;
    mid();
    n_total++; if ({if_ready, if_rdata} !== {1'b1, 32'h42}) $display("FAIL drq_ready: got rdy=%b rdata=%h want 1 00000042", if_ready, if_rdata); else n_pass++;
    next(); mem_rvalid = 1'b0;
    next();
  endtask

  task automatic test_delayed_grant();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h5000;
    for (int i = 0; i < 4; i++) begin
      next();
      mid();
      n_total++; if ({mem_req, mem_addr, d_ready, stall_m} !== {1'b1, 32'h5000, 1'b0, 1'b1}) $display("FAIL dg_hold%0d: got req=%b addr=%h rdy=%b want 1 00005000 0", i, mem_req, mem_addr, d_ready); else n_pass++;
    end
    next(); mem_gnt = 1'b1;
    next(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
    mid();
    n_total++; if ({d_ready, d_rdata} !== {1'b1, 32'h77}) $display("FAIL dg_ready: got rdy=%b rdata=%h want 1 00000077", d_ready, d_rdata); else n_pass++;
    next(); mem_rvalid = 1'b0; d_req = 1'b0;
    next();
  endtask

  task automatic test_write_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h4000; d_wdata = 32'hDEAD_BEEF; d_wmask = 4'b0011;
    next(); mem_gnt = 1'b1;
    mid();
    n_total++; if ({mem_req, mem_we, mem_wmask} !== 6'b1_1_0011) $display("FAIL wr_ctl: got req=%b we=%b mask=%b want 1 1 0011", mem_req, mem_we, mem_wmask); else n_pass++;
    n_total++; if ({mem_addr, mem_wdata} !== {32'h4000, 32'hDEAD_BEEF}) $display("FAIL wr_data: got addr=%h wdata=%h want 00004000 deadbeef", mem_addr, mem_wdata); else n_pass++;
    next(); mem_gnt = 1'b0; reset = 1'b0;
    mid();
    n_total++; if ({mem_req, stall_m, d_ready, d_rdata, if_rdata} !== 67'h0) $display("FAIL wr_rst: got req=%b stall=%b if_rdata=%h want 0", mem_req, stall_m, if_rdata); else n_pass++;
    next(); reset = 1'b1; d_req = 1'b0; d_we = 1'b0; d_wmask = 4'h0;
    next(); mem_rvalid = 1'b1; mem_rdata = 32'h55;
    mid();
    n_total++; if ({d_ready, d_rdata, mem_req} !== {1'b0, 32'h0, 1'b0}) $display("FAIL wr_stale: got rdy=%b rdata=%h req=%b want 0 00000000 0", d_ready, d_rdata, mem_req); else n_pass++;
    next(); mem_rvalid = 1'b0;
    next();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_flush();
    test_dropped_req();
    test_delayed_grant();
    test_write_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
